// File: rtl/npu_pkg.sv
// Shared widths, state encoding and int8 limits for the NPU writeback paths.
package npu_pkg;

  localparam int ACC_W    = 32;
  localparam int MULT_W   = 16;
  localparam int SHIFT_W  = 5;
  localparam int C_ADDR_W = 10;
  localparam int C_DATA_W = 8;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_DRAIN
  } wb_state_t;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

endpackage

// File: rtl/requant_stage.sv
// Combinational requantizer: rounding arithmetic right shift, zero-point add,
// saturation to int8. Sits between a product register and an output register.
module requant_stage
  import npu_pkg::*;
(
  input  logic signed [ACC_W+MULT_W-1:0] prod,
  input  logic        [SHIFT_W-1:0]      shift,
  input  logic signed [C_DATA_W-1:0]     zero_point,
  output logic        [C_DATA_W-1:0]     result
);

  localparam int PROD_W = ACC_W + MULT_W;
  localparam int VW     = PROD_W + 1;

  localparam logic signed [VW-1:0] SAT_HI = VW'(INT8_MAX);
  localparam logic signed [VW-1:0] SAT_LO = VW'(INT8_MIN);

  logic signed [VW-1:0] prod_x;
  logic signed [VW-1:0] rnd;
  logic signed [VW-1:0] sum;
  logic signed [VW-1:0] r;
  logic signed [VW-1:0] v;

  always_comb begin
    // One extra bit of headroom keeps the rounding add and zero-point add exact.
    prod_x = {prod[PROD_W-1], prod};
    rnd    = '0;
    if (shift != '0) begin
      rnd = VW'(1) << (shift - SHIFT_W'(1));
    end
    sum = prod_x + rnd;
    r   = sum >>> shift;
    v   = r + VW'(zero_point);
    if (v > SAT_HI) begin
      result = SAT_HI[C_DATA_W-1:0];
    end else if (v < SAT_LO) begin
      result = SAT_LO[C_DATA_W-1:0];
    end else begin
      result = v[C_DATA_W-1:0];
    end
  end

endmodule

// File: rtl/c_writeback.sv
// C-buffer writeback: accepts accumulator beats, requantizes to int8 and
// writes them to consecutive SRAM addresses from a latched base, then pulses done.
module c_writeback
  import npu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic        [C_ADDR_W-1:0] base_addr,
  input  logic        [C_ADDR_W:0]   count,
  input  logic signed [MULT_W-1:0]   mult,
  input  logic        [SHIFT_W-1:0]  shift,
  input  logic signed [C_DATA_W-1:0] zero_point,
  input  logic                       acc_valid,
  input  logic signed [ACC_W-1:0]    acc_data,
  output logic                       acc_ready,
  output logic                       sram_ce,
  output logic                       sram_we,
  output logic        [C_ADDR_W-1:0] sram_addr,
  output logic        [C_DATA_W-1:0] sram_din,
  output logic                       busy,
  output logic                       done
);

  localparam int PROD_W = ACC_W + MULT_W;
  localparam int CNT_W  = C_ADDR_W + 1;

  wb_state_t state_reg, state_next;
  logic ready_reg, ready_next;
  logic done_reg, done_next;

  logic        [CNT_W-1:0]    count_reg;
  logic        [CNT_W-1:0]    accepted_reg;
  logic        [C_ADDR_W-1:0] wr_addr_reg;
  logic signed [MULT_W-1:0]   mult_reg;
  logic        [SHIFT_W-1:0]  shift_reg;
  logic signed [C_DATA_W-1:0] zp_reg;

  logic signed [PROD_W-1:0]   prod_reg;
  logic                       prod_valid_reg;
  logic                       we_reg;
  logic        [C_ADDR_W-1:0] addr_reg;
  logic        [C_DATA_W-1:0] din_reg;
  logic        [C_DATA_W-1:0] requant_result;

  logic fire;
  logic job_start;
  logic last_beat;

  assign fire      = acc_valid && ready_reg;
  assign job_start = (state_reg == WB_IDLE) && start && (count != '0);
  assign last_beat = fire && ((accepted_reg + CNT_W'(1)) == count_reg);

  always_comb begin
    state_next = state_reg;
    ready_next = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      WB_IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_next = WB_RUN;
            ready_next = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      WB_RUN: begin
        ready_next = !last_beat;
        if (last_beat) begin
          state_next = WB_DRAIN;
        end
      end
      WB_DRAIN: begin
        // Last strobe is on the outputs and nothing is left in the product stage.
        if (we_reg && !prod_valid_reg) begin
          state_next = WB_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WB_IDLE;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      accepted_reg <= '0;
      mult_reg     <= '0;
      shift_reg    <= '0;
      zp_reg       <= '0;
    end else if (job_start) begin
      count_reg    <= count;
      accepted_reg <= '0;
      mult_reg     <= mult;
      shift_reg    <= shift;
      zp_reg       <= zero_point;
    end else if (fire) begin
      accepted_reg <= accepted_reg + CNT_W'(1);
    end
  end

  // Write address advances per issued write, so input gaps never skip addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_reg <= '0;
    end else if (job_start) begin
      wr_addr_reg <= base_addr;
    end else if (prod_valid_reg) begin
      wr_addr_reg <= wr_addr_reg + C_ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_valid_reg <= 1'b0;
      prod_reg       <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      din_reg        <= '0;
    end else begin
      prod_valid_reg <= fire;
      if (fire) begin
        prod_reg <= PROD_W'(acc_data) * PROD_W'(mult_reg);
      end
      we_reg <= prod_valid_reg;
      if (prod_valid_reg) begin
        addr_reg <= wr_addr_reg;
        din_reg  <= requant_result;
      end
    end
  end

  requant_stage u_requant (
    .prod       (prod_reg),
    .shift      (shift_reg),
    .zero_point (zp_reg),
    .result     (requant_result)
  );

  assign acc_ready = ready_reg;
  assign sram_ce   = we_reg;
  assign sram_we   = we_reg;
  assign sram_addr = addr_reg;
  assign sram_din  = din_reg;
  assign busy      = (state_reg != WB_IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_c_writeback.sv
// Self-checking bench for c_writeback: table vectors plus scoreboarded jobs
// covering saturation, rounding, wrap, gaps, zero count and mid-job reset.
module tb_c_writeback;
  import npu_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       start = 1'b0;
  logic        [C_ADDR_W-1:0] base_addr = '0;
  logic        [C_ADDR_W:0]   count = '0;
  logic signed [MULT_W-1:0]   mult = '0;
  logic        [SHIFT_W-1:0]  shift = '0;
  logic signed [C_DATA_W-1:0] zero_point = '0;
  logic                       acc_valid = 1'b0;
  logic signed [ACC_W-1:0]    acc_data = '0;
  logic                       acc_ready, sram_ce, sram_we, busy, done;
  logic        [C_ADDR_W-1:0] sram_addr;
  logic        [C_DATA_W-1:0] sram_din;

  c_writeback dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .mult(mult), .shift(shift), .zero_point(zero_point), .acc_valid(acc_valid),
    .acc_data(acc_data), .acc_ready(acc_ready), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data;} exp_t;
  typedef struct {int mult; int sh; int zp; int acc; int exp;} vec_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   strobe_cyc[$];
  int   job_acc[$];
  logic [7:0] mem [1024];
  bit   touched [1024];
  int   strobe_count = 0;
  int   done_count = 0;
  int   last_we_cyc = -10;
  int   done_cyc = -10;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic int model(int acc, int m, int sh, int zp);
    longint p, r, v;
    p = longint'(acc) * longint'(m);
    if (sh == 0) r = p;
    else r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    v = r + zp;
    if (v > INT8_MAX) v = INT8_MAX;
    if (v < INT8_MIN) v = INT8_MIN;
    return int'(v) & 255;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (sram_we || sram_ce) check("ce_eq_we", sram_ce, sram_we);
      if (sram_we) begin
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", sram_addr, e.addr);
          check("wr_data", sram_din, e.data);
        end
        mem[sram_addr] = sram_din;
        touched[sram_addr] = 1'b1;
        strobe_count++;
        last_we_cyc = cyc;
        strobe_cyc.push_back(cyc);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        check("busy_low_on_done", busy, 0);
      end
      if (!busy) check("ready_low_when_idle", acc_ready, 0);
    end
  end

  task automatic run_job(input int base, input int cnt, input int m, input int sh, input int zp,
                         input logic [15:0] vpat, input int vlen, input bit poke, input bit b2b);
    int idx, step, s0, d0, guard;
    idx = 0; step = 0; s0 = strobe_count; d0 = done_count;
    @(negedge clk);
    start = 1'b1; base_addr = base[9:0]; count = cnt[10:0];
    mult = m[15:0]; shift = sh[4:0]; zero_point = zp[7:0];
    @(negedge clk);
    start = 1'b0;
    base_addr = 10'($urandom); count = 11'($urandom); mult = 16'($urandom);
    shift = 5'($urandom); zero_point = 8'($urandom);
    check("busy_after_start", busy, 1);
    while (idx < cnt && step < 200) begin
      @(negedge clk);
      if (poke && step == 1) begin
        start = 1'b1; base_addr = 10'd500; count = 11'd3;
      end else begin
        start = 1'b0;
      end
      acc_valid = vpat[step % vlen];
      acc_data  = job_acc[idx];
      if (acc_valid && acc_ready) begin
        exp_q.push_back('{addr: (base + idx) % 1024, data: model(job_acc[idx], m, sh, zp)});
        idx++;
      end
      step++;
    end
    check("beats_accepted", idx, cnt);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0; acc_valid = 1'b1; acc_data = 32'sd99;
      check("ready_low_after_last", acc_ready, 0);
    end
    acc_valid = 1'b0;
    guard = 0;
    while (done_count == d0 && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    check("done_seen", done_count - d0, 1);
    check("done_after_last_strobe", done_cyc, last_we_cyc + 1);
    check("strobe_count", strobe_count - s0, cnt);
    if (b2b && strobe_cyc.size() >= s0 + cnt)
      check("b2b_strobes", strobe_cyc[s0 + cnt - 1] - strobe_cyc[s0], cnt - 1);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_acc_ready"}, acc_ready, 0);
    check({tag, "_sram_ce"}, sram_ce, 0);
    check({tag, "_sram_we"}, sram_we, 0);
    check({tag, "_sram_addr"}, sram_addr, 0);
    check({tag, "_sram_din"}, sram_din, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[8];
    int gs[3], gl[3], gb[3];
    int idx, guard, s0, s1, n;

    tbl[0] = '{1, 0, 0, 5, 8'h05};
    tbl[1] = '{1, 0, 0, -3, 8'hFD};
    tbl[2] = '{1, 0, 0, 200, 8'h7F};
    tbl[3] = '{1, 0, 0, -200, 8'h80};
    tbl[4] = '{3, 2, 10, 5, 8'h0E};
    tbl[5] = '{3, 2, 10, -5, 8'h06};
    tbl[6] = '{1, 2, 10, 2, 8'h0B};
    tbl[7] = '{1, 2, 10, -2, 8'h0A};
    gs = '{0, 4, 6}; gl = '{4, 2, 2}; gb = '{0, 16, 32};

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Saturation and rounding vectors, one job per parameter group.
    for (int g = 0; g < 3; g++) begin
      job_acc.delete();
      for (int i = 0; i < gl[g]; i++) job_acc.push_back(tbl[gs[g] + i].acc);
      run_job(gb[g], gl[g], tbl[gs[g]].mult, tbl[gs[g]].sh, tbl[gs[g]].zp, 16'hFFFF, 16, 1'b0, 1'b1);
      for (int i = 0; i < gl[g]; i++)
        check($sformatf("tbl%0d_mem", gs[g] + i), mem[gb[g] + i], tbl[gs[g] + i].exp);
    end

    // Address wrap from 1022.
    for (int i = 0; i < 1024; i++) touched[i] = 1'b0;
    job_acc.delete();
    for (int i = 0; i < 4; i++) job_acc.push_back(int'($urandom_range(0, 400)) - 200);
    run_job(1022, 4, -7, 3, -5, 16'hFFFF, 16, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 1024; i++) n += int'(touched[i]);
    check("wrap_touched_total", n, 4);
    check("wrap_t1022", touched[1022], 1);
    check("wrap_t1023", touched[1023], 1);
    check("wrap_t0", touched[0], 1);
    check("wrap_t1", touched[1], 1);

    // Valid gaps 1,0,0,1,1,0,1 with a start pulse during RUN.
    job_acc.delete();
    for (int i = 0; i < 4; i++) job_acc.push_back(int'($urandom_range(0, 4000)) - 2000);
    run_job(200, 4, 300, 9, 3, 16'b0000_0000_0101_1001, 7, 1'b1, 1'b0);

    // Zero-count job.
    s0 = strobe_count;
    @(negedge clk);
    start = 1'b1; count = '0; base_addr = 10'd5;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    @(negedge clk);
    check("zero_done_pulse", done, 0);
    check("zero_no_write", strobe_count - s0, 0);

    // Reset after two strobes of a six-beat job.
    job_acc = '{10, 11, 12, 13, 14, 15};
    s0 = strobe_count;
    @(negedge clk);
    start = 1'b1; base_addr = 10'd300; count = 11'd6; mult = 16'sd1; shift = '0; zero_point = '0;
    @(negedge clk);
    start = 1'b0;
    idx = 0; guard = 0;
    while (strobe_count - s0 < 2 && guard < 40) begin
      @(negedge clk);
      acc_valid = (idx < 6);
      acc_data  = job_acc[(idx < 6) ? idx : 0];
      if (acc_valid && acc_ready) begin
        exp_q.push_back('{addr: 300 + idx, data: model(job_acc[idx], 1, 0, 0)});
        idx++;
      end
      #1; guard++;
    end
    check("rst_two_strobes", strobe_count - s0, 2);
    rst = 1'b1; acc_valid = 1'b0;
    #1;
    check_outputs_zero("midrst");
    check("midrst_mem300", mem[300], 10);
    check("midrst_mem301", mem[301], 11);
    exp_q.delete();
    s1 = strobe_count;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_more_strobes", strobe_count, s1);
    check("midrst_idle", busy, 0);

    job_acc.delete();
    for (int i = 0; i < 3; i++) job_acc.push_back(int'($urandom_range(0, 600)) - 300);
    run_job(40, 3, 2, 1, 0, 16'hFFFF, 16, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
